uart_rx_fifo_ctrl: RTL and testbench
====================================

// Module: uart_rx_fifo_ctrl
// PURPOSE
//  Second-generation UART receiver: runtime baud divisor, 16x oversampling with 3-sample majority vote,
//  configurable word length, optional parity, 1/2 stop bits. Received words go into an internal FWFT FIFO
//  drained by a valid/ready handshake; framing, parity and overrun errors are sticky.
//  Sits between the serial pin and the peripheral bus register block.
// PARAMETERS
//  F_CLK        16000000  system clock frequency in Hz (documentation/bench use only)
//  DATA_WIDTH   8         bits per word, legal range 5..9, sent LSB first
//  OVERSAMPLE   16        oversample ticks per bit, even, >= 8
//  DIV_WIDTH    16        width of baud_div
//  FIFO_DEPTH   16        RX FIFO entries, power of 2, >= 2
// PORTS
//  clk_16mhz    in   1                          system clock
//  rstn         in   1                          asynchronous active-low reset
//  baud_div     in   DIV_WIDTH                  clocks per oversample tick minus 1 (tick period = baud_div+1)
//  parity_en    in   1                          1: a parity bit follows the data bits
//  parity_odd   in   1                          1: odd parity, 0: even parity
//  stop_bits2   in   1                          1: two stop bits checked, 0: one
//  serial_in    in   1                          asynchronous serial line, idle high
//  rx_data      out  DATA_WIDTH                 FIFO head word, valid when rx_valid=1
//  rx_valid     out  1                          FIFO not empty
//  rx_ready     in   1                          consumer pops the head when rx_valid & rx_ready
//  fifo_count   out  $clog2(FIFO_DEPTH+1)       number of stored words
//  rx_busy      out  1                          FSM not in IDLE
//  frame_err    out  1                          sticky: a stop bit was sampled low
//  parity_err   out  1                          sticky: parity mismatch
//  overrun_err  out  1                          sticky: a good word arrived while FIFO full
//  err_clr      in   1                          single-cycle pulse clears all three sticky flags
// BEHAVIOUR
//  - Reset (async): all outputs 0; FSM to IDLE; FIFO emptied; synchroniser flops set to 1 (line idle).
//  - serial_in passes through a 2-flop synchroniser; all logic uses the synchronised value (2-clk latency).
//  - Tick gen: counter 0..baud_div, tick on the terminal count; counter is cleared on start detect.
//    baud_div, parity_en, parity_odd and stop_bits2 are captured at start detect; changes mid-frame take
//    effect on the next frame only.
//  - Bit timing: an oversample counter 0..OVERSAMPLE-1 advances on each tick. Samples are taken at counts
//    OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1; the bit value is the 2-of-3 majority, decided at
//    count OVERSAMPLE/2+1. A bit ends at count OVERSAMPLE-1.
//  - FSM: IDLE -> START on a synchronised 1->0 edge. START: vote=1 -> IDLE (false start, no error,
//    nothing pushed); otherwise -> DATA at bit end. DATA: shifts DATA_WIDTH bits LSB first, then ->
//    PARITY if parity_en else -> STOP. PARITY: one bit, compared against the XOR of the data bits
//    (inverted for odd). STOP: one or two bits; the frame completes at the vote of the last stop bit and
//    the FSM returns to IDLE immediately at that vote (mid-bit), so a back-to-back start edge is caught.
//  - Completion: any stop vote = 0 -> frame_err set, word dropped. Parity mismatch -> parity_err set,
//    word dropped. Both may set in the same frame. Otherwise the word is pushed; if the FIFO is full and
//    no pop occurs that cycle -> word dropped, overrun_err set, FIFO contents untouched.
//  - A line held low (break) yields one frame_err; no further frames start until a fresh 1->0 edge.
//  - FIFO: first-word-fall-through. A push becomes visible on rx_data/rx_valid on the next clock.
//    Pop and push in the same cycle: count unchanged; when full, the push is accepted (no overrun).
//    A pop while empty is ignored. Pointers wrap modulo FIFO_DEPTH.
//  - Sticky errors: err_clr clears them; a set event in the same cycle as err_clr wins (flag stays 1).
// TESTING
//  1. baud_div=8 (bit=144 clk), 8N1, send 0xA5 -> exactly one push, rx_data=0xA5, all error flags 0.
//  2. serial_in low 40 clk then high -> rx_busy pulses then returns 0, no push, no error flag set.
//  3. parity_en=1, parity_odd=0, send 0x3C with parity bit 1 -> no push, parity_err=1; err_clr -> 0.
//  4. stop bit driven 0, then line held low 5000 clk -> one frame_err, no push, rx_busy stays 0 after.
//  5. rx_ready=0, send 17 words 0x00..0x10 -> fifo_count=16, overrun_err=1, drain returns 0x00..0x0F.
//  6. 1-clk low glitch on the middle sample of a '1' data bit -> word correct; rstn pulse mid-frame -> idle.

Source files
------------

// File: rtl/uart_rx_fifo_ctrl_if.sv
// Receive-word handshake between the UART RX FIFO (master) and its consumer (slave).
interface uart_rx_fifo_ctrl_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receiver: runtime baud divisor, 3-sample majority vote, optional parity, 1/2 stop bits,
// feeding a first-word-fall-through FIFO with sticky framing/parity/overrun flags.
module uart_rx_fifo_ctrl #(
   parameter int F_CLK      = 16000000,
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_WIDTH  = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                            clk_16mhz,
   input  logic                            rstn,
   input  logic [DIV_WIDTH-1:0]            baud_div,
   input  logic                            parity_en,
   input  logic                            parity_odd,
   input  logic                            stop_bits2,
   input  logic                            serial_in,
   uart_rx_fifo_ctrl_if.master             rx_bus,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
   output logic                            rx_busy,
   output logic                            frame_err,
   output logic                            parity_err,
   output logic                            overrun_err,
   input  logic                            err_clr
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int OW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_WIDTH);
   localparam logic [OW-1:0] OS_S0   = OW'(OVERSAMPLE / 2 - 1);
   localparam logic [OW-1:0] OS_S1   = OW'(OVERSAMPLE / 2);
   localparam logic [OW-1:0] OS_VOTE = OW'(OVERSAMPLE / 2 + 1);
   localparam logic [OW-1:0] OS_END  = OW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

   if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || F_CLK <= 0) begin : g_param_check
      $error("uart_rx_fifo_ctrl: illegal parameter set");
   end

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic parity_mismatch(input logic [DATA_WIDTH-1:0] word, input logic odd,
                                            input logic pbit);
      return pbit != ((^word) ^ odd);
   endfunction

   state_t                 state, state_nxt;
   logic                   sync_p0, sync_p1, line_p2;
   logic                   start_det;
   logic [DIV_WIDTH-1:0]   tick_cnt, div_q;
   logic                   par_en_q, par_odd_q, stop2_q;
   logic                   tick, at_vote, at_end, vote;
   logic [OW-1:0]          os_cnt;
   logic                   samp0, samp1;
   logic [BW-1:0]          bit_idx;
   logic                   stop_idx, stop_bad, par_bit;
   logic [DATA_WIDTH-1:0]  shreg;
   logic                   frame_done, set_ferr, set_perr, set_oerr, push_req;
   logic                   pop, full, push_ok;
   logic [AW-1:0]          wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];

   // Stage p0/p1: line synchroniser; p2 holds the previous synchronised level for edge detect
   always_ff @(posedge clk_16mhz or negedge rstn) begin
      if (!rstn) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
         line_p2 <= 1'b1;
      end else begin
         sync_p0 <= serial_in;
         sync_p1 <= sync_p0;
         line_p2 <= sync_p1;
      end
   end

   assign start_det = (state == ST_IDLE) && line_p2 && !sync_p1;
   assign tick      = (tick_cnt == div_q);
   assign at_vote   = tick && (os_cnt == OS_VOTE);
   assign at_end    = tick && (os_cnt == OS_END);
   assign vote      = majority3(samp0, samp1, sync_p1);

   always_ff @(posedge clk_16mhz or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:   if (start_det) state_nxt = ST_START;
         ST_START:  if (at_vote && vote) state_nxt = ST_IDLE;
                    else if (at_end) state_nxt = ST_DATA;
         ST_DATA:   if (at_end && bit_idx == BIT_LAST) state_nxt = par_en_q ? ST_PARITY : ST_STOP;
         ST_PARITY: if (at_end) state_nxt = ST_STOP;
         ST_STOP:   if (at_vote && stop_idx == stop2_q) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // The frame completes mid-bit at the last stop vote so a back-to-back start edge is not missed
   always_comb begin
      rx_busy    = (state != ST_IDLE);
      frame_done = (state == ST_STOP) && at_vote && (stop_idx == stop2_q);
      set_ferr   = frame_done && (stop_bad || !vote);
      set_perr   = frame_done && par_en_q && parity_mismatch(shreg, par_odd_q, par_bit);
      push_req   = frame_done && !set_ferr && !set_perr;
   end

   always_ff @(posedge clk_16mhz or negedge rstn) begin
      if (!rstn) begin
         tick_cnt  <= '0;
         div_q     <= '0;
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         stop2_q   <= 1'b0;
         os_cnt    <= '0;
         samp0     <= 1'b1;
         samp1     <= 1'b1;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         stop_bad  <= 1'b0;
         par_bit   <= 1'b0;
      end else if (start_det) begin
         tick_cnt  <= '0;
         div_q     <= baud_div;
         par_en_q  <= parity_en;
         par_odd_q <= parity_odd;
         stop2_q   <= stop_bits2;
         os_cnt    <= '0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         stop_bad  <= 1'b0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         if (tick) begin
            os_cnt <= at_end ? '0 : os_cnt + 1'b1;
            if (os_cnt == OS_S0) samp0 <= sync_p1;
            if (os_cnt == OS_S1) samp1 <= sync_p1;
         end
         if (at_vote && state == ST_PARITY) par_bit <= vote;
         if (at_vote && state == ST_STOP && !vote) stop_bad <= 1'b1;
         if (at_end && state == ST_DATA) bit_idx <= bit_idx + 1'b1;
         if (at_end && state == ST_STOP) stop_idx <= 1'b1;
      end
   end

   always_ff @(posedge clk_16mhz) begin
      if (state == ST_DATA && at_vote) shreg <= {vote, shreg[DATA_WIDTH-1:1]};
   end

   // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted
   assign pop      = rx_bus.rx_valid && rx_bus.rx_ready;
   assign full     = (fifo_count == CW'(FIFO_DEPTH));
   assign push_ok  = push_req && (!full || pop);
   assign set_oerr = push_req && full && !pop;

   always_ff @(posedge clk_16mhz) begin
      if (push_ok) mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge clk_16mhz or negedge rstn) begin
      if (!rstn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         fifo_count <= fifo_count + CW'(push_ok) - CW'(pop);
      end
   end

   assign rx_bus.rx_valid = (fifo_count != '0);
   assign rx_bus.rx_data  = rx_bus.rx_valid ? mem[rd_ptr] : '0;

   // A set event outranks err_clr in the same cycle
   always_ff @(posedge clk_16mhz or negedge rstn) begin
      if (!rstn) begin
         frame_err   <= 1'b0;
         parity_err  <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         frame_err   <= set_ferr || (frame_err   && !err_clr);
         parity_err  <= set_perr || (parity_err  && !err_clr);
         overrun_err <= set_oerr || (overrun_err && !err_clr);
      end
   end
endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Directed and randomized frames against a queue-based reference of the UART RX FIFO controller.
`timescale 1ns/1ps
module tb_uart_rx_fifo_ctrl;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk_16mhz = 1'b0;
   logic          rstn = 1'b0;
   logic [15:0]   baud_div = 16'd8;
   logic          parity_en = 1'b0, parity_odd = 1'b0, stop_bits2 = 1'b0;
   logic          serial_in = 1'b1, err_clr = 1'b0;
   logic [CW-1:0] fifo_count;
   logic          rx_busy, frame_err, parity_err, overrun_err;

   uart_rx_fifo_ctrl_if #(.DATA_WIDTH(DW)) rx_bus ();

   uart_rx_fifo_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk_16mhz  (clk_16mhz),
      .rstn       (rstn),
      .baud_div   (baud_div),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .stop_bits2 (stop_bits2),
      .serial_in  (serial_in),
      .rx_bus     (rx_bus),
      .fifo_count (fifo_count),
      .rx_busy    (rx_busy),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun_err(overrun_err),
      .err_clr    (err_clr)
   );

   always #31 clk_16mhz = ~clk_16mhz;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_q[$];
   logic exp_ferr = 1'b0, exp_perr = 1'b0, exp_oerr = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk_16mhz);
   endtask

   task automatic check_state(input string tag);
      check({tag, ".count"}, 32'(fifo_count), 32'(exp_q.size()));
      check({tag, ".valid"}, 32'(rx_bus.rx_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) check({tag, ".head"}, 32'(rx_bus.rx_data), 32'(exp_q[0]));
      check({tag, ".frame_err"}, 32'(frame_err), 32'(exp_ferr));
      check({tag, ".parity_err"}, 32'(parity_err), 32'(exp_perr));
      check({tag, ".overrun_err"}, 32'(overrun_err), 32'(exp_oerr));
      check({tag, ".busy"}, 32'(rx_busy), 32'd0);
   endtask

   task automatic drain(input string tag);
      rx_bus.rx_ready = 1'b1;
      while (exp_q.size() != 0) begin
         check({tag, ".drain"}, 32'(rx_bus.rx_data), 32'(exp_q.pop_front()));
         @(negedge clk_16mhz);
      end
      rx_bus.rx_ready = 1'b0;
      check({tag, ".empty"}, 32'(rx_bus.rx_valid), 32'd0);
      check({tag, ".count0"}, 32'(fifo_count), 32'd0);
   endtask

   task automatic clear_errors();
      @(negedge clk_16mhz) err_clr = 1'b1;
      @(negedge clk_16mhz) err_clr = 1'b0;
      exp_ferr = 1'b0;
      exp_perr = 1'b0;
      exp_oerr = 1'b0;
   endtask

   task automatic reset_dut();
      @(negedge clk_16mhz);
      rstn = 1'b0;
      serial_in = 1'b1;
      clks(3);
      exp_q.delete();
      exp_ferr = 1'b0;
      exp_perr = 1'b0;
      exp_oerr = 1'b0;
      check("reset.busy_in_reset", 32'(rx_busy), 32'd0);
      check("reset.data", 32'(rx_bus.rx_data), 32'd0);
      rstn = 1'b1;
      clks(4);
   endtask

   // Drives one frame; the model then applies the receiver's completion rules to what was sent.
   task automatic send_frame(input logic [DW-1:0] data, input logic pen, input logic podd,
                             input logic st2, input logic par_flip, input logic [1:0] stop_low,
                             input int div, input int glitch_bit, input int glitch_off,
                             input bit scramble, input bit hold_low);
      logic bits[$];
      logic req_par, sent_par, fe, pe;
      int   bt;
      bt = 16 * (div + 1);
      baud_div = 16'(div);
      parity_en = pen;
      parity_odd = podd;
      stop_bits2 = st2;
      serial_in = 1'b1;
      clks(4);
      req_par  = 1'(($countones(data) % 2) == 1) ^ podd;
      sent_par = req_par ^ par_flip;
      bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) bits.push_back(data[i]);
      if (pen) bits.push_back(sent_par);
      bits.push_back(~stop_low[0]);
      if (st2) bits.push_back(~stop_low[1]);
      foreach (bits[b]) begin
         for (int c = 0; c < bt; c++) begin
            @(negedge clk_16mhz);
            serial_in = (b == glitch_bit && c == glitch_off) ? 1'b0 : bits[b];
            if (scramble && b == 1 && c == 0) begin
               baud_div   = 16'($urandom_range(0, 40));
               parity_en  = 1'($urandom);
               parity_odd = 1'($urandom);
               stop_bits2 = 1'($urandom);
            end
         end
      end
      if (!hold_low) begin
         @(negedge clk_16mhz);
         serial_in = 1'b1;
      end
      fe = stop_low[0] || (st2 && stop_low[1]);
      pe = pen && (sent_par != req_par);
      if (fe) exp_ferr = 1'b1;
      if (pe) exp_perr = 1'b1;
      if (!fe && !pe) begin
         if (exp_q.size() >= DEPTH) exp_oerr = 1'b1;
         else exp_q.push_back(data);
      end
      clks(2);
   endtask

   initial begin
      rx_bus.rx_ready = 1'b0;
      clks(3);
      check_state("reset");
      check("reset.data0", 32'(rx_bus.rx_data), 32'd0);
      rstn = 1'b1;
      clks(5);

      // 8N1 at baud_div=8
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8, -1, 0, 1'b0, 1'b0);
      check_state("8n1_a5");
      check("8n1_a5.one_word", 32'(fifo_count), 32'd1);
      drain("8n1_a5");

      // Short low pulse: false start
      @(negedge clk_16mhz) serial_in = 1'b0;
      clks(10);
      check("false_start.busy", 32'(rx_busy), 32'd1);
      clks(30);
      serial_in = 1'b1;
      clks(200);
      check_state("false_start");

      // Even parity with wrong parity bit
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 8, -1, 0, 1'b0, 1'b0);
      check_state("parity_bad");
      clear_errors();
      check_state("parity_clr");

      // Stop bit low then break
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 8, -1, 0, 1'b0, 1'b1);
      check_state("break_frame");
      for (int i = 0; i < 5; i++) begin
         clks(1000);
         check_state("break_hold");
      end
      serial_in = 1'b1;
      clks(50);
      check_state("break_release");
      clear_errors();

      // Fill beyond depth with consumer stalled
      for (int w = 0; w <= DEPTH; w++) begin
         send_frame(8'(w), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2, -1, 0, 1'b0, 1'b0);
      end
      check_state("overrun");
      check("overrun.full", 32'(fifo_count), 32'(DEPTH));
      check("overrun.flag", 32'(overrun_err), 32'd1);
      drain("overrun");
      clear_errors();
      check_state("overrun_clr");

      // One-clock glitch on the middle sample of data bit 1 (a '1')
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8, 2, 9 + 9 * 8, 1'b0, 1'b0);
      check_state("glitch");
      drain("glitch");

      // Reset in the middle of a frame
      @(negedge clk_16mhz) serial_in = 1'b0;
      clks(300);
      check("midreset.busy", 32'(rx_busy), 32'd1);
      reset_dut();
      check_state("midreset");

      // Randomized frames with mid-frame config changes
      for (int n = 0; n < 14; n++) begin
         logic [DW-1:0] d;
         logic pen, podd, st2, pflip;
         logic [1:0] sl;
         d     = 8'($urandom);
         pen   = 1'($urandom);
         podd  = 1'($urandom);
         st2   = 1'($urandom);
         pflip = pen && ($urandom_range(0, 5) == 0);
         sl    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         send_frame(d, pen, podd, st2, pflip, sl, int'($urandom_range(1, 3)), -1, 0, 1'b1, 1'b0);
         check_state("random");
         if ($urandom_range(0, 3) == 0 || exp_q.size() >= 12) drain("random");
         if ($urandom_range(0, 2) == 0) begin
            clear_errors();
            check_state("random_clr");
         end
      end
      drain("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
